// File: rtl/arp_frame_gen_if.sv
// AXI-Stream byte-lane bus (32-bit data, 4 keep bits) carrying generated Ethernet frames.
interface arp_frame_gen_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;

    modport master (
        output tdata, tkeep, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/arp_frame_gen.sv
// ARP request frame source on AXI-Stream; periodic or one-shot.
// Define ARP_GEN_PAD_EN to zero-pad the frame to 60 bytes (15 words) instead of 42 bytes (11 words).
module arp_frame_gen #(
    parameter int          INTERVAL = 62500,
    parameter logic [47:0] SRC_MAC  = 48'h00e04c68a1bd,
    parameter logic [31:0] SRC_IP   = 32'hc0a80181,
    parameter logic [31:0] DST_IP   = 32'hc0a8010a
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               trigger,
    arp_frame_gen_if.master    m_axis,
    output logic               busy,
    output logic [15:0]        frame_count
);

`ifdef ARP_GEN_PAD_EN
    localparam logic [3:0] LAST_IDX  = 4'd14;
    localparam logic [3:0] LAST_KEEP = 4'hf;
`else
    localparam logic [3:0] LAST_IDX  = 4'd10;
    localparam logic [3:0] LAST_KEEP = 4'h3;
`endif

    localparam logic [31:0] INTERVAL_LD = 32'(INTERVAL);

    // Wire-order byte stream; first byte sits in the top bits.
    localparam logic [335:0] ARP_BYTES = {
        48'hffffffffffff, SRC_MAC, 16'h0806,
        16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001,
        SRC_MAC, SRC_IP, 48'h000000000000, DST_IP
    };
    localparam logic [511:0] FRAME_BYTES = {ARP_BYTES, 176'h0};

    // Byte n of the frame lands on lane n%4 of word n/4.
    logic [15:0][31:0] word_rom;
    for (genvar gi = 0; gi < 16; gi++) begin : g_word
        assign word_rom[gi] = {
            FRAME_BYTES[511 - 8*(4*gi + 3) -: 8],
            FRAME_BYTES[511 - 8*(4*gi + 2) -: 8],
            FRAME_BYTES[511 - 8*(4*gi + 1) -: 8],
            FRAME_BYTES[511 - 8*(4*gi + 0) -: 8]
        };
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state_reg;
    logic [3:0]  idx_reg;
    logic [31:0] cnt_reg;
    logic        pending_reg;
    logic [31:0] tdata_reg;
    logic [3:0]  tkeep_reg;
    logic        tvalid_reg;
    logic        tlast_reg;
    logic        busy_reg;
    logic [15:0] count_reg;

    logic [3:0]  idx_next;
    logic        handshake;

    assign idx_next  = idx_reg + 4'd1;
    assign handshake = tvalid_reg & m_axis.tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            cnt_reg     <= INTERVAL_LD;
            pending_reg <= 1'b0;
            tdata_reg   <= '0;
            tkeep_reg   <= '0;
            tvalid_reg  <= 1'b0;
            tlast_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            count_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // A trigger coinciding with expiry folds into the same start.
                    if (pending_reg || trigger || (enable && cnt_reg == '0)) begin
                        state_reg   <= SEND;
                        idx_reg     <= '0;
                        pending_reg <= 1'b0;
                        cnt_reg     <= INTERVAL_LD;
                        tdata_reg   <= word_rom[0];
                        tkeep_reg   <= 4'hf;
                        tvalid_reg  <= 1'b1;
                        tlast_reg   <= 1'b0;
                        busy_reg    <= 1'b1;
                    end else if (enable) begin
                        cnt_reg <= cnt_reg - 32'd1;
                    end
                end
                SEND: begin
                    if (trigger) begin
                        pending_reg <= 1'b1;
                    end
                    if (handshake) begin
                        if (tlast_reg) begin
                            state_reg  <= IDLE;
                            cnt_reg    <= INTERVAL_LD;
                            tdata_reg  <= '0;
                            tkeep_reg  <= '0;
                            tvalid_reg <= 1'b0;
                            tlast_reg  <= 1'b0;
                            busy_reg   <= 1'b0;
                            count_reg  <= count_reg + 16'd1;
                        end else begin
                            idx_reg   <= idx_next;
                            tdata_reg <= word_rom[idx_next];
                            tkeep_reg <= (idx_next == LAST_IDX) ? LAST_KEEP : 4'hf;
                            tlast_reg <= (idx_next == LAST_IDX);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign m_axis.tdata  = tdata_reg;
    assign m_axis.tkeep  = tkeep_reg;
    assign m_axis.tvalid = tvalid_reg;
    assign m_axis.tlast  = tlast_reg;
    assign m_axis.tuser  = 1'b0;
    assign busy          = busy_reg;
    assign frame_count   = count_reg;

endmodule
